// File: rtl/sb_tx_serializer_if.sv
// Write-side bus between the sideband TX wrapper and the serializer.
// Signal names keep the serializer's legacy port names.
interface sb_tx_serializer_if;
    logic        i_write_enable;
    logic [63:0] i_tx_data_in;
    logic        i_flush;
    logic        o_fifo_full;
    logic        o_overflow;

    modport master (
        output i_write_enable,
        output i_tx_data_in,
        output i_flush,
        input  o_fifo_full,
        input  o_overflow
    );

    modport slave (
        input  i_write_enable,
        input  i_tx_data_in,
        input  i_flush,
        output o_fifo_full,
        output o_overflow
    );
endinterface

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: buffers 64-bit packets and shifts them out LSB-first
// with a gated forwarded clock and a fixed low gap after every packet.
module sb_tx_serializer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned GAP_UI = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    sb_tx_serializer_if.slave         io_wr,
    output logic                      o_ser_done,
    output logic                      o_txdata_sb,
    output logic                      o_txclk_en,
    output logic                      o_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = (GAP_UI > 1) ? $clog2(GAP_UI) : 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_UI - 1);
    localparam logic [5:0]    BIT_LAST = 6'd63;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic [1:0]    r_state;
    logic [63:0]   r_shreg;
    logic [5:0]    r_bit_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic          r_ser_done;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_pop;
    logic w_last_bit;
    logic w_last_gap;

    assign w_full     = (r_count == CNT_FULL);
    assign w_empty    = (r_count == '0);
    // Fullness is judged on the registered count, so a pop in the same cycle
    // never makes room for a write to a full buffer.
    assign w_wr_acc   = io_wr.i_write_enable && !w_full && !io_wr.i_flush;
    assign w_pop      = (r_state == ST_IDLE) && !w_empty && !io_wr.i_flush;
    assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_cnt == BIT_LAST);
    assign w_last_gap = (r_state == ST_GAP) && (r_gap_cnt == GAP_LAST);

    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= io_wr.i_tx_data_in;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (io_wr.i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= r_count + CW'(w_wr_acc) - CW'(w_pop);
            r_overflow <= io_wr.i_write_enable && w_full;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_ser_done <= 1'b0;
        end else if (io_wr.i_flush) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_ser_done <= 1'b0;
        end else begin
            r_ser_done <= w_last_bit;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shreg   <= r_mem[r_rd_ptr];
                        r_bit_cnt <= '0;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shreg   <= {1'b0, r_shreg[63:1]};
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                    if (w_last_bit) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_last_gap) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Serial outputs decode the registered state so reset silences them at once.
    assign o_txclk_en        = (r_state == ST_SHIFT);
    assign o_txdata_sb       = o_txclk_en && r_shreg[0];
    assign o_ser_done        = r_ser_done;
    assign o_busy            = (r_state != ST_IDLE) || !w_empty;
    assign io_wr.o_fifo_full = w_full;
    assign io_wr.o_overflow  = r_overflow;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Directed bench for sb_tx_serializer (DEPTH=4, GAP_UI=32): cycle-exact timing,
// overflow, back-to-back spacing, flush and asynchronous reset.
module tb_sb_tx_serializer;

    logic clk;
    logic rst;
    logic ser_done;
    logic txdata;
    logic txclk_en;
    logic busy;

    sb_tx_serializer_if wr ();

    sb_tx_serializer #(
        .DEPTH  (4),
        .GAP_UI (32)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .io_wr       (wr),
        .o_ser_done  (ser_done),
        .o_txdata_sb (txdata),
        .o_txclk_en  (txclk_en),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Line monitor: reassembles packets, counts pulses, measures idle gaps.
    logic [63:0] rx_q[$];
    int          gap_q[$];
    logic [63:0] m_cur      = '0;
    int          m_nbits    = 0;
    int          m_gap_run  = 0;
    bit          m_had_data = 0;
    bit          m_prev_en  = 0;
    int          n_done     = 0;
    int          n_ovf      = 0;

    always @(negedge clk) begin
        if (txclk_en === 1'b1) begin
            if (m_had_data && !m_prev_en) gap_q.push_back(m_gap_run);
            m_cur = {txdata, m_cur[63:1]};
            m_nbits++;
            if (m_nbits == 64) begin
                rx_q.push_back(m_cur);
                m_nbits = 0;
            end
            m_had_data = 1;
            m_gap_run  = 0;
        end else begin
            m_nbits = 0;
            m_gap_run++;
        end
        m_prev_en = (txclk_en === 1'b1);
        if (ser_done === 1'b1) n_done++;
        if (wr.o_overflow === 1'b1) n_ovf++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < bound) begin
            tick();
            c++;
        end
        chk(tag, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int          bad;
    int          rx0;
    int          gp0;
    int          dn0;
    int          ov0;
    int          sent;
    int          guard;
    logic [63:0] bdat [5];
    logic [63:0] qdat [5];
    logic [63:0] wdat [9];

    initial begin
        bdat[0] = 64'h0123_4567_89AB_CDEF;
        bdat[1] = 64'hDEAD_BEEF_0000_0001;
        bdat[2] = 64'h8000_0000_0000_0000;
        bdat[3] = 64'hFFFF_0000_FFFF_0000;
        bdat[4] = 64'h5555_AAAA_3333_CCCC;
        for (int k = 0; k < 9; k++)
            wdat[k] = {32'hC0DE_0000 + 32'(k), 32'h8765_4321 ^ (32'(k) * 32'h0101_0101)};
        qdat[0] = 64'h1111_2222_3333_4444;
        qdat[1] = 64'h0000_0000_0000_0003;
        qdat[2] = 64'hF0F0_F0F0_0F0F_0F0F;
        qdat[3] = 64'h7FFF_FFFF_FFFF_FFFE;
        qdat[4] = 64'hA5A5_A5A5_A5A5_A5A5;

        // Reset state
        rst = 1'b1;
        wr.i_write_enable = 1'b0;
        wr.i_tx_data_in   = '0;
        wr.i_flush        = 1'b0;
        repeat (3) tick();
        chk("rst_txclk_en", {63'd0, txclk_en}, 64'd0);
        chk("rst_txdata",   {63'd0, txdata},   64'd0);
        chk("rst_ser_done", {63'd0, ser_done}, 64'd0);
        chk("rst_busy",     {63'd0, busy},     64'd0);
        chk("rst_full",     {63'd0, wr.o_fifo_full}, 64'd0);
        chk("rst_overflow", {63'd0, wr.o_overflow},  64'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Single packet, cycle-exact timing relative to write cycle t
        tick();
        wr.i_write_enable = 1'b1;
        wr.i_tx_data_in   = 64'h0000_0000_0000_0001;
        tick();
        wr.i_write_enable = 1'b0;
        chk("t1_en_t+1",   {63'd0, txclk_en}, 64'd0);
        chk("t1_busy_t+1", {63'd0, busy},     64'd1);
        tick();
        chk("t1_en_t+2",   {63'd0, txclk_en}, 64'd1);
        chk("t1_data_t+2", {63'd0, txdata},   64'd1);
        bad = 0;
        for (int k = 3; k <= 65; k++) begin
            tick();
            if (txclk_en !== 1'b1 || txdata !== 1'b0 || ser_done !== 1'b0) bad++;
        end
        chk("t1_bits_t+3..65", 64'(bad), 64'd0);
        tick();
        chk("t1_done_t+66", {63'd0, ser_done}, 64'd1);
        chk("t1_en_t+66",   {63'd0, txclk_en}, 64'd0);
        bad = 0;
        for (int k = 67; k <= 97; k++) begin
            tick();
            if (txclk_en !== 1'b0 || txdata !== 1'b0 || ser_done !== 1'b0) bad++;
        end
        chk("t1_gap_t+67..97", 64'(bad), 64'd0);
        chk("t1_busy_t+97", {63'd0, busy}, 64'd1);
        tick();
        chk("t1_busy_t+98", {63'd0, busy}, 64'd0);
        chk("t1_rx", rx_q[rx_q.size()-1], 64'h1);

        // Five writes while a packet shifts: fill, then one dropped
        repeat (5) tick();
        rx0 = rx_q.size(); gp0 = gap_q.size(); dn0 = n_done; ov0 = n_ovf;
        tick();
        wr.i_write_enable = 1'b1;
        wr.i_tx_data_in   = 64'hCAFE_F00D_1234_5679;
        tick();
        wr.i_write_enable = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 3) chk("t2_full_before4", {63'd0, wr.o_fifo_full}, 64'd0);
            if (k == 4) chk("t2_full_after4",  {63'd0, wr.o_fifo_full}, 64'd1);
            wr.i_write_enable = 1'b1;
            wr.i_tx_data_in   = bdat[k];
            tick();
        end
        wr.i_write_enable = 1'b0;
        chk("t2_overflow_pulse", {63'd0, wr.o_overflow}, 64'd1);
        tick();
        chk("t2_overflow_clear", {63'd0, wr.o_overflow}, 64'd0);
        wait_idle("t2_idle_timeout", 700);
        chk("t2_rx_count",   64'(rx_q.size() - rx0), 64'd5);
        chk("t2_done_count", 64'(n_done - dn0), 64'd5);
        chk("t2_ovf_count",  64'(n_ovf - ov0),  64'd1);
        if (rx_q.size() - rx0 == 5) begin
            chk("t2_rx_first", rx_q[rx0], 64'hCAFE_F00D_1234_5679);
            for (int k = 0; k < 4; k++)
                chk($sformatf("t2_rx_b%0d", k), rx_q[rx0+1+k], bdat[k]);
        end
        if (gap_q.size() - gp0 == 5) begin
            for (int k = 1; k < 5; k++)
                chk($sformatf("t2_gap%0d", k), 64'(gap_q[gp0+k]), 64'd33);
        end else begin
            chk("t2_gap_count", 64'(gap_q.size() - gp0), 64'd5);
        end

        // Nine packets keeping the buffer non-empty: spacing and pointer wrap
        repeat (3) tick();
        rx0 = rx_q.size(); gp0 = gap_q.size(); dn0 = n_done; ov0 = n_ovf;
        sent = 0; guard = 0;
        while (sent < 9 && guard < 2000) begin
            tick();
            if (wr.o_fifo_full === 1'b0) begin
                wr.i_write_enable = 1'b1;
                wr.i_tx_data_in   = wdat[sent];
                sent++;
            end else begin
                wr.i_write_enable = 1'b0;
            end
            guard++;
        end
        tick();
        wr.i_write_enable = 1'b0;
        chk("t3_sent", 64'(sent), 64'd9);
        wait_idle("t3_idle_timeout", 1200);
        chk("t3_rx_count",   64'(rx_q.size() - rx0), 64'd9);
        chk("t3_done_count", 64'(n_done - dn0), 64'd9);
        chk("t3_ovf_count",  64'(n_ovf - ov0),  64'd0);
        if (rx_q.size() - rx0 == 9) begin
            for (int k = 0; k < 9; k++)
                chk($sformatf("t3_rx%0d", k), rx_q[rx0+k], wdat[k]);
        end
        bad = 0;
        for (int k = 1; k < 9; k++)
            if (gp0 + k >= gap_q.size() || gap_q[gp0+k] != 33) bad++;
        chk("t3_gaps_33", 64'(bad), 64'd0);

        // Flush at bit 20 with two entries queued
        repeat (3) tick();
        tick();
        wr.i_write_enable = 1'b1;
        wr.i_tx_data_in   = 64'h0000_0000_0010_0000;
        tick();
        wr.i_tx_data_in   = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        wr.i_tx_data_in   = 64'h1357_9BDF_2468_ACE0;
        tick();
        wr.i_write_enable = 1'b0;
        repeat (19) tick();
        chk("t4_en_bit20",   {63'd0, txclk_en}, 64'd1);
        chk("t4_data_bit20", {63'd0, txdata},   64'd1);
        rx0 = rx_q.size(); dn0 = n_done;
        wr.i_flush = 1'b1;
        tick();
        wr.i_flush = 1'b0;
        chk("t4_en_after",   {63'd0, txclk_en}, 64'd0);
        chk("t4_busy_after", {63'd0, busy},     64'd0);
        chk("t4_done_after", {63'd0, ser_done}, 64'd0);
        repeat (80) tick();
        chk("t4_no_done",   64'(n_done - dn0), 64'd0);
        chk("t4_no_rx",     64'(rx_q.size() - rx0), 64'd0);
        chk("t4_busy_late", {63'd0, busy}, 64'd0);
        wr.i_write_enable = 1'b1;
        wr.i_tx_data_in   = 64'h8421_0000_FEDC_BA99;
        tick();
        wr.i_write_enable = 1'b0;
        chk("t4_new_en_t+1", {63'd0, txclk_en}, 64'd0);
        tick();
        chk("t4_new_en_t+2", {63'd0, txclk_en}, 64'd1);
        chk("t4_new_bit0",   {63'd0, txdata},   64'd1);
        wait_idle("t4_idle_timeout", 200);
        chk("t4_new_done", 64'(n_done - dn0), 64'd1);
        chk("t4_new_rx",   rx_q[rx_q.size()-1], 64'h8421_0000_FEDC_BA99);

        // Asynchronous reset in the middle of a packet
        repeat (3) tick();
        wr.i_write_enable = 1'b1;
        wr.i_tx_data_in   = '1;
        tick();
        wr.i_write_enable = 1'b0;
        repeat (11) tick();
        chk("t5_en_pre",   {63'd0, txclk_en}, 64'd1);
        chk("t5_data_pre", {63'd0, txdata},   64'd1);
        dn0 = n_done; rx0 = rx_q.size();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_en_rst",   {63'd0, txclk_en}, 64'd0);
        chk("t5_data_rst", {63'd0, txdata},   64'd0);
        chk("t5_busy_rst", {63'd0, busy},     64'd0);
        tick();
        rst = 1'b0;
        repeat (100) tick();
        chk("t5_no_done", 64'(n_done - dn0), 64'd0);
        chk("t5_no_rx",   64'(rx_q.size() - rx0), 64'd0);
        chk("t5_busy",    {63'd0, busy}, 64'd0);

        // Full buffer: pop and write in the same IDLE cycle
        rx0 = rx_q.size(); dn0 = n_done; ov0 = n_ovf;
        tick();
        wr.i_write_enable = 1'b1;
        wr.i_tx_data_in   = 64'h0000_0000_DEAD_0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            wr.i_tx_data_in = qdat[k];
        end
        tick();
        wr.i_write_enable = 1'b0;
        chk("t6_full_t+5", {63'd0, wr.o_fifo_full}, 64'd1);
        repeat (93) tick();
        chk("t6_full_idle", {63'd0, wr.o_fifo_full}, 64'd1);
        chk("t6_en_idle",   {63'd0, txclk_en},       64'd0);
        wr.i_write_enable = 1'b1;
        wr.i_tx_data_in   = qdat[4];
        tick();
        wr.i_write_enable = 1'b0;
        chk("t6_overflow",  {63'd0, wr.o_overflow},  64'd1);
        chk("t6_full_after",{63'd0, wr.o_fifo_full}, 64'd0);
        chk("t6_en_after",  {63'd0, txclk_en},       64'd1);
        wait_idle("t6_idle_timeout", 600);
        chk("t6_rx_count",   64'(rx_q.size() - rx0), 64'd5);
        chk("t6_done_count", 64'(n_done - dn0), 64'd5);
        chk("t6_ovf_count",  64'(n_ovf - ov0),  64'd1);
        if (rx_q.size() - rx0 == 5) begin
            chk("t6_rx_first", rx_q[rx0], 64'h0000_0000_DEAD_0000);
            for (int k = 0; k < 4; k++)
                chk($sformatf("t6_rx_q%0d", k), rx_q[rx0+1+k], qdat[k]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sb_tx_serializer.md
SB_TX_SERIALIZER -- requirements
Module: sb_tx_serializer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of 64-bit packet buffer entries (power of two, >=2).
REQ-002 The block SHALL have parameter GAP_UI, default 32, meaning the number of low, clock-gated cycles inserted after every packet.
REQ-003 The block SHALL have port i_clk  input  1  sideband serial clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port i_write_enable  input  1  packet write strobe from the sideband TX wrapper.
REQ-006 The block SHALL have port i_tx_data_in  input  64  packet to serialize; bit 0 is transmitted first.
REQ-007 The block SHALL have port i_flush  input  1  synchronous abort: empty the buffer and stop the current transmission.
REQ-008 The block SHALL have port o_fifo_full  output  1  buffer holds DEPTH packets; back-pressure to the TX wrapper.
REQ-009 The block SHALL have port o_ser_done  output  1  one-cycle pulse marking the end of each packet's 64th bit.
REQ-010 The block SHALL have port o_txdata_sb  output  1  serial sideband data.
REQ-011 The block SHALL have port o_txclk_en  output  1  forwarded-clock gate enable; high only while data bits are driven.
REQ-012 The block SHALL have port o_overflow  output  1  one-cycle pulse when a write is dropped.
REQ-013 The block SHALL have port o_busy  output  1  high when state is not IDLE or the buffer is non-empty.

Function
REQ-014 The buffer SHALL be a circular FIFO with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits.
REQ-015 o_fifo_full SHALL equal (count == DEPTH), combinationally from the registered count.
REQ-016 A write SHALL be accepted iff i_write_enable=1, count<DEPTH and i_flush=0; an accepted write stores i_tx_data_in and is visible in count on the next cycle.
REQ-017 When a write is attempted with count==DEPTH, it SHALL be dropped even if a pop occurs in the same cycle, and o_overflow SHALL be 1 on the next cycle.
REQ-018 A simultaneous accepted write and pop SHALL leave count unchanged.
REQ-019 The FSM SHALL have states IDLE, SHIFT and GAP and reset to IDLE.
REQ-020 IDLE: if count>0, the block SHALL pop the head entry into a 64-bit shift register, load bit counter 0 and enter SHIFT; otherwise it stays in IDLE.
REQ-021 SHIFT: o_txdata_sb SHALL be shreg[0] and o_txclk_en SHALL be 1; each cycle the register shifts right by one and the bit counter increments.
REQ-022 From SHIFT, the block SHALL move to GAP after the 64th bit cycle (counter==63).
REQ-023 o_ser_done SHALL be registered and high for exactly the first GAP cycle.
REQ-024 GAP: o_txdata_sb and o_txclk_en SHALL be 0 for GAP_UI cycles, then the FSM returns to IDLE.
REQ-025 Packet spacing SHALL be fixed: write at cycle t into an empty, idle block gives first bit at t+2; back-to-back packets are separated by GAP_UI+1 non-data cycles.
REQ-026 In IDLE, o_txdata_sb and o_txclk_en SHALL be 0.
REQ-027 i_flush=1 SHALL, on the next edge: zero the pointers and count, enter IDLE, and clear the shift register and counters; o_ser_done SHALL not pulse for the aborted packet.
REQ-028 i_flush SHALL have priority over write and pop in the same cycle.

Reset
REQ-029 While i_rst=1, the block SHALL force state=IDLE, pointers/count/bit and gap counters=0, and shift register=0.
REQ-030 While i_rst=1, all outputs SHALL be 0.
REQ-031 Reset asserted mid-packet SHALL stop transmission immediately (asynchronously) with no o_ser_done pulse.
REQ-032 Buffer memory contents need no reset.

Verification
REQ-033 Write 64'h0000_0000_0000_0001 at cycle t into an idle block -> o_txclk_en high t+2..t+65; o_txdata_sb=1 only at t+2; o_ser_done pulse at t+66; o_txclk_en=0 for t+66..t+97; o_busy=0 from t+98.
REQ-034 Write 5 packets on consecutive cycles with DEPTH=4 -> o_fifo_full=1 after the 4th; 5th write dropped with an o_overflow pulse; exactly 4 o_ser_done pulses, packets emitted in write order LSB-first.
REQ-035 Keep the buffer non-empty -> inter-packet spacing is exactly 33 non-data cycles with GAP_UI=32; pointers wrap correctly over >=2*DEPTH packets.
REQ-036 Assert i_flush at bit 20 of a packet with 2 entries queued -> next cycle: o_txclk_en=0, count=0, no o_ser_done pulse; a new write serializes normally.
REQ-037 Assert i_rst mid-SHIFT -> outputs 0 within the same cycle; after release with no writes, no o_ser_done pulse and o_busy=0.
REQ-038 Full buffer with a simultaneous pop and write -> write dropped, o_overflow pulse, count becomes DEPTH-1.
